// File: rtl/cordic_pkg.sv
// Shared constants, payload types and helpers for the CORDIC datapath.
//   DATA_W    : working register width (Q2.14 for x/y, Q3.13 for z)
//   ITER_N    : micro-rotations per operation
//   ITR_W     : width of the iteration index
//   K_Q15     : CORDIC gain compensation factor 0.60725 in Q1.15
//   ATAN_TAB  : round(atan(2^-i) * 2^13), entry i in slice [i]
// Optional feature macro: CORDIC_GAIN_COMP_EN (used by cordic_datapath).
package cordic_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ITER_N = 16;
  localparam int unsigned ITR_W  = $clog2(ITER_N);

  localparam logic signed [DATA_W-1:0] K_Q15 = 16'sd19898;

  // Listed from index 15 down to index 0.
  localparam logic [ITER_N-1:0][DATA_W-1:0] ATAN_TAB = {
    16'd0,    16'd0,    16'd1,    16'd2,
    16'd4,    16'd8,    16'd16,   16'd32,
    16'd64,   16'd128,  16'd256,  16'd511,
    16'd1019, 16'd2007, 16'd3798, 16'd6434
  };

  // Working vector payload: x, y in Q2.14, z in Q3.13.
  typedef struct packed {
    logic signed [DATA_W-1:0] x;
    logic signed [DATA_W-1:0] y;
    logic signed [DATA_W-1:0] z;
  } vec_t;

  // (v * K_Q15) >>> 15, truncated to DATA_W bits.
  function automatic logic signed [DATA_W-1:0] gain_comp(input logic signed [DATA_W-1:0] v);
    logic signed [2*DATA_W-1:0] prod;
    prod = (2*DATA_W)'(v) * (2*DATA_W)'(K_Q15);
    return prod[DATA_W+14:15];
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup for the CORDIC micro-rotation angle.
//   idx     : iteration index i
//   angle_c : ATAN[i] in Q3.13 radians
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [ITR_W-1:0]         idx,
  output logic signed [DATA_W-1:0] angle_c
);

  assign angle_c = ATAN_TAB[idx];

endmodule

// File: rtl/cordic_datapath.sv
// Iterative CORDIC rotation-mode datapath driven by an external controller.
//   clk, rst            : clock, synchronous active-high reset
//   init, ld            : init+ld loads operands, ld alone does one micro-rotation
//   fin                 : capture x/y/z into the result registers
//   x_in, y_in, z_in    : start vector (Q2.14) and angle (Q3.13)
//   itr                 : current iteration index
//   x_out, y_out, z_out : captured result vector and residual angle
//   res_vld             : one-cycle pulse after a capture
// Optional feature: define CORDIC_GAIN_COMP_EN to scale captured x/y by K_Q15.
module cordic_datapath
  import cordic_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     init,
  input  logic                     ld,
  input  logic                     fin,
  input  logic signed [DATA_W-1:0] x_in,
  input  logic signed [DATA_W-1:0] y_in,
  input  logic signed [DATA_W-1:0] z_in,
  output logic [ITR_W-1:0]         itr,
  output logic signed [DATA_W-1:0] x_out,
  output logic signed [DATA_W-1:0] y_out,
  output logic signed [DATA_W-1:0] z_out,
  output logic                     res_vld
);

  vec_t                     st;
  vec_t                     rot_c;
  vec_t                     cap_c;
  vec_t                     load_c;
  logic signed [DATA_W-1:0] atan_c;
  logic signed [DATA_W-1:0] x_sh_c;
  logic signed [DATA_W-1:0] y_sh_c;

  cordic_atan_rom u_atan_rom (
    .idx     (itr),
    .angle_c (atan_c)
  );

  assign load_c = '{x: x_in, y: y_in, z: z_in};

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    rot_c  = st;
    x_sh_c = st.x >>> itr;
    y_sh_c = st.y >>> itr;
    if (st.z[DATA_W-1]) begin
      rot_c.x = st.x + y_sh_c;
      rot_c.y = st.y - x_sh_c;
      rot_c.z = st.z + atan_c;
    end else begin
      rot_c.x = st.x - y_sh_c;
      rot_c.y = st.y + x_sh_c;
      rot_c.z = st.z - atan_c;
    end
  end

  // Result value presented to the output registers; z is never scaled.
  always_comb begin
    cap_c = st;
`ifdef CORDIC_GAIN_COMP_EN
    cap_c.x = gain_comp(st.x);
    cap_c.y = gain_comp(st.y);
`else
    cap_c.x = st.x;
    cap_c.y = st.y;
`endif
  end

  // Working registers and iteration counter; itr wraps 15 -> 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      st  <= '0;
      itr <= '0;
    end else if (ld) begin
      if (init) begin
        st  <= load_c;
        itr <= '0;
      end else begin
        st  <= rot_c;
        itr <= itr + ITR_W'(1);
      end
    end
  end

  // Result capture samples pre-update state when fin and ld coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_out   <= '0;
      y_out   <= '0;
      z_out   <= '0;
      res_vld <= 1'b0;
    end else begin
      res_vld <= fin;
      if (fin) begin
        x_out <= cap_c.x;
        y_out <= cap_c.y;
        z_out <= cap_c.z;
      end
    end
  end

endmodule

// File: tb/tb_cordic_datapath.sv
// Directed and randomized checks of cordic_datapath against a bench model
// with a scoreboard of expected captures.
module tb_cordic_datapath;

  logic               clk;
  logic               rst;
  logic               init;
  logic               ld;
  logic               fin;
  logic signed [15:0] x_in;
  logic signed [15:0] y_in;
  logic signed [15:0] z_in;
  logic [3:0]         itr;
  logic signed [15:0] x_out;
  logic signed [15:0] y_out;
  logic signed [15:0] z_out;
  logic               res_vld;

  cordic_datapath dut (
    .clk     (clk),
    .rst     (rst),
    .init    (init),
    .ld      (ld),
    .fin     (fin),
    .x_in    (x_in),
    .y_in    (y_in),
    .z_in    (z_in),
    .itr     (itr),
    .x_out   (x_out),
    .y_out   (y_out),
    .z_out   (z_out),
    .res_vld (res_vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int z;
  } cap_t;

  cap_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   atan_tab[16];
  int   mx, my, mz, mitr;
  int   mxo, myo, mzo;
  int   mvld;

  function automatic int w16(input int v);
    logic signed [15:0] t;
    t = 16'(v);
    return int'(t);
  endfunction

  function automatic int m_comp(input int v);
`ifdef CORDIC_GAIN_COMP_EN
    return w16((v * 19898) >>> 15);
`else
    return v;
`endif
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_tol(input string tag, input int obs, input int exp, input int tol);
    n_chk++;
    assert ((iabs(obs - exp) <= tol) === 1'b1) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  // One clock cycle: drive, advance model, sample after the edge and compare.
  task automatic cyc(input logic r, input logic i, input logic l, input logic f,
                     input int xi, input int yi, input int zi);
    cap_t c;
    int   xs, ys, nx, ny, nz;
    @(negedge clk);
    rst  = r;
    init = i;
    ld   = l;
    fin  = f;
    x_in = 16'(xi);
    y_in = 16'(yi);
    z_in = 16'(zi);
    if (r) begin
      mx = 0; my = 0; mz = 0; mitr = 0;
      mxo = 0; myo = 0; mzo = 0; mvld = 0;
      q.delete();
    end else begin
      mvld = int'(f);
      if (f) begin
        c.x = m_comp(mx);
        c.y = m_comp(my);
        c.z = mz;
        q.push_back(c);
        mxo = c.x; myo = c.y; mzo = c.z;
      end
      if (l && i) begin
        mx = w16(xi); my = w16(yi); mz = w16(zi); mitr = 0;
      end else if (l) begin
        xs = mx >>> mitr;
        ys = my >>> mitr;
        if (mz >= 0) begin
          nx = mx - ys; ny = my + xs; nz = mz - atan_tab[mitr];
        end else begin
          nx = mx + ys; ny = my - xs; nz = mz + atan_tab[mitr];
        end
        mx = w16(nx); my = w16(ny); mz = w16(nz);
        mitr = (mitr + 1) % 16;
      end
    end
    @(posedge clk);
    #1;
    chk("itr", int'(itr), mitr);
    chk("res_vld", int'(res_vld), mvld);
    chk("x_out", int'(x_out), mxo);
    chk("y_out", int'(y_out), myo);
    chk("z_out", int'(z_out), mzo);
    if (res_vld) begin
      chk("sb_pending", int'(q.size() > 0), 1);
      if (q.size() > 0) begin
        c = q.pop_front();
        chk("sb_x", int'(x_out), c.x);
        chk("sb_y", int'(y_out), c.y);
        chk("sb_z", int'(z_out), c.z);
      end
    end
  endtask

  task automatic load(input int xi, input int yi, input int zi);
    cyc(1'b0, 1'b1, 1'b1, 1'b0, xi, yi, zi);
  endtask

  task automatic iter(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 0);
  endtask

  task automatic capture();
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 0, 0, 0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  int za, zb;

  initial begin
    rst = 1'b1; init = 1'b0; ld = 1'b0; fin = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    mx = 0; my = 0; mz = 0; mitr = 0; mxo = 0; myo = 0; mzo = 0; mvld = 0;
    for (int i = 0; i < 16; i++)
      atan_tab[i] = int'($floor($atan($pow(2.0, -1.0 * i)) * 8192.0 + 0.5));

    // Reset, with every control asserted to show reset priority.
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h1111, 16'h2222, 16'h3333);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);

    // Single micro-rotation from (1.0, 0) at angle 0.
    load(16'h4000, 0, 0);
    iter(1);
    chk("one_itr", int'(itr), 1);
    capture();
`ifdef CORDIC_GAIN_COMP_EN
    chk("one_x", int'(x_out), 9949);
    chk("one_y", int'(y_out), 9949);
`else
    chk("one_x", int'(x_out), 16384);
    chk("one_y", int'(y_out), 16384);
`endif
    chk("one_z", int'(z_out), -6434);
    idle();

    // Full run at angle 0.
    load(16'h4000, 0, 0);
    iter(16);
    chk("run0_itr", int'(itr), 0);
    capture();
`ifdef CORDIC_GAIN_COMP_EN
    chk_tol("run0_x", int'(x_out), 16384, 4);
    chk_tol("run0_y", int'(y_out), 0, 4);
`else
    chk_tol("run0_x", int'(x_out), 26981, 4);
    chk_tol("run0_y", int'(y_out), 0, 4);
`endif
    idle();
    chk("run0_vld_drop", int'(res_vld), 0);

    // Outputs and state hold with ld low, even with init high.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h7fff, 16'h7fff, 16'h7fff);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h5678, 16'h0abc);
    capture();

    // Full run at pi/4.
    load(16'h4000, 0, 6434);
    iter(16);
    capture();
`ifdef CORDIC_GAIN_COMP_EN
    chk_tol("pi4_x", int'(x_out), 11585, 4);
    chk_tol("pi4_y", int'(y_out), 11585, 4);
`else
    chk_tol("pi4_x", int'(x_out), 19078, 4);
    chk_tol("pi4_y", int'(y_out), 19078, 4);
`endif
    chk_tol("pi4_z", int'(z_out), 0, 2);
    idle();

    // Seventeen rotations: index wraps and the 17th step uses ATAN[0].
    load(16'h3000, 16'h0800, -2000);
    iter(16);
    chk("wrap_itr", int'(itr), 0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
    za = int'(z_out);
    chk("wrap_itr17", int'(itr), 1);
    capture();
    zb = int'(z_out);
    chk("wrap_atan0", iabs(zb - za), 6434);

    // Reset at iteration 7, then clean restart.
    load(16'h2000, 16'h1000, 3000);
    iter(7);
    chk("rst_pre_itr", int'(itr), 7);
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 16'h0101, 16'h0202, 16'h0303);
    chk("rst_x_out", int'(x_out), 0);
    chk("rst_itr", int'(itr), 0);
    capture();
    chk("rst_state_x", int'(x_out), 0);
    load(16'h4000, 0, 0);
    chk("restart_itr", int'(itr), 0);
    iter(1);
    capture();
    chk("restart_z", int'(z_out), -6434);

    // Reload at iteration 9 with new operands.
    load(16'h3800, -16'h0400, 5000);
    iter(9);
    load(16'h1234, -16'h0800, 1000);
    chk("reload_itr", int'(itr), 0);
    capture();
`ifndef CORDIC_GAIN_COMP_EN
    chk("reload_x", int'(x_out), 16'h1234);
    chk("reload_y", int'(y_out), -16'h0800);
`endif
    chk("reload_z", int'(z_out), 1000);

    // Random operands with fin alongside every ld (pre-update capture).
    for (int r = 0; r < 4; r++) begin
      load(int'($urandom_range(0, 32767)) - 16384, int'($urandom_range(0, 32767)) - 16384,
           int'($urandom_range(0, 25736)) - 12868);
      for (int k = 0; k < 16; k++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 0, 0, 0);
      capture();
      idle();
    end

    chk("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cordic_datapath.md
CORDIC_DATAPATH -- requirements
Module: cordic_datapath

Interface
REQ-001 The block SHALL expose these ports, one per entry (name, direction, width, meaning):
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- init  in  1  from controller; with ld, loads operands.
- ld  in  1  from controller; register-update enable.
- fin  in  1  from controller; capture-result strobe.
- x_in, y_in  in  16  signed Q2.14 start vector.
- z_in  in  16  signed Q3.13 rotation angle, radians.
- itr  out  4  current iteration index, consumed by controller.
- x_out, y_out  out  16  signed Q2.14 result vector.
- z_out  out  16  signed Q3.13 residual angle.
- res_vld  out  1  one-cycle pulse, result outputs updated.
REQ-002 There is one clock; reset SHALL be synchronous and active-high.

Function
REQ-003 The block SHALL hold internal working registers x, y, z (16 bit each) and the itr counter (4 bit).
REQ-004 When init=1 and ld=1, the block SHALL load x<=x_in, y<=y_in, z<=z_in and itr<=0 on the next edge.
REQ-005 When ld=1 and init=0, the block SHALL perform one micro-rotation using index i=itr.
- Direction: d=+1 if z>=0, else d=-1.
- x<=x-d*(y>>>i); y<=y+d*(x>>>i); z<=z-d*ATAN[i].
- itr<=itr+1.
REQ-006 Shifts SHALL be arithmetic; all adds/subtracts SHALL be 16-bit two's complement with wrap, no saturation.
REQ-007 itr SHALL wrap from 15 to 0.
REQ-008 With ld=0, x, y, z and itr SHALL hold, regardless of init.
REQ-009 ATAN[i] SHALL be round(atan(2^-i)*2^13) for i=0..15; ATAN[0]=6434.
REQ-010 A full operation SHALL take 1 load cycle plus 16 iteration cycles with itr=0..15; the controller leaves EXEC when it sees itr==15.
REQ-011 On fin=1, the block SHALL register x_out/y_out/z_out from x/y/z (post-compensation, see Configuration) on the next edge, and res_vld SHALL be 1 for exactly that following cycle.
REQ-012 x_out/y_out/z_out SHALL hold between fin strobes.
REQ-013 If fin and ld are both 1 in the same cycle, the capture SHALL use pre-update x/y/z, and the update SHALL proceed.
REQ-014 If init=1 with ld=1 arrives mid-operation, the block SHALL reload and restart from itr=0.

Reset
REQ-015 With rst=1, all outputs and internal registers SHALL reset to 0 on the next edge (x, y, z, itr, x_out, y_out, z_out, res_vld).
REQ-016 rst SHALL take priority over init, ld and fin; reset mid-operation SHALL abandon the computation.

Configuration
REQ-017 CORDIC_GAIN_COMP_EN defined: at fin capture, x_out and y_out SHALL equal (x*K_Q15)>>>15 with K_Q15=19898 (0.60725), truncated to 16 bit.
REQ-018 CORDIC_GAIN_COMP_EN undefined: raw x and y SHALL be captured.
REQ-019 z_out and all latencies SHALL be unaffected by CORDIC_GAIN_COMP_EN.

Structure
REQ-020 Package cordic_pkg SHALL hold:
- data width (16) and iteration count (16);
- K_Q15;
- the ATAN table constants.
REQ-021 A combinational sub-module cordic_atan_rom (4-bit index in, 16-bit angle out) SHALL supply ATAN[i].

Verification
REQ-022 Load x_in=0x4000, y_in=0, z_in=0, then one ld cycle -> x=0x4000, y=0x4000, z=-6434, itr=1.
REQ-023 Load x_in=0x4000, y_in=0, z_in=0, then 16 ld cycles and fin:
- without CORDIC_GAIN_COMP_EN -> x_out=26981±4, y_out=0±4;
- with CORDIC_GAIN_COMP_EN -> x_out=16384±4;
- in both cases res_vld=1 for one cycle.
REQ-024 z_in=6434 (pi/4), x_in=0x4000, y_in=0, full run, compensation on -> x_out=y_out=11585±4, z_out=0±2.
REQ-025 Hold ld=1 for 17 iteration cycles -> itr goes 15 to 0 and the 17th rotation uses ATAN[0].
REQ-026 Assert rst at iteration 7 -> all registers and outputs are 0 next cycle; a subsequent init+ld restarts cleanly from itr=0.
REQ-027 Assert init+ld at iteration 9 with new operands -> itr=0 and the new operands are loaded next cycle.
